uart_tx_scheduler: RTL and testbench

- Shares the single UART `sender` transmit path among `NREQ` byte producers using round-robin arbitration; examples are the CPU MMIO path, a debug tracer and a DMA.
- Supports packet locking, so a multi-byte message is never interleaved with another requester's bytes.
- Sits between the requesters and the `sender` instance: drives `txdata`/`txen`, watches `txstatus`, and holds data stable for the whole frame.
- Flags a launch that the sender never acknowledges.

---
 rtl/uart_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/uart_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The MMIO addresses are the CPU-side view of the sender registers.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  localparam logic [31:0] UART_TXDATA_ADDR   = 32'h4000_0018;
  localparam logic [31:0] UART_TXEN_ADDR     = 32'h4000_001C;
  localparam logic [31:0] UART_TXSTATUS_ADDR = 32'h4000_0020;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_ptr, wrapping.
// While i_lock is set only the locked owner is eligible.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_lock,
  input  logic [IDW-1:0]  i_lock_id,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id,
  output logic            o_valid
);

  always_comb begin
    int             w_sum;
    logic [IDW-1:0] w_cand;
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    o_grant    = '0;
    o_grant_id = '0;
    o_valid    = 1'b0;
    w_sum      = 0;
    w_cand     = '0;
    if (i_lock) begin
      if (i_req[i_lock_id]) begin
        o_valid    = 1'b1;
        o_grant_id = i_lock_id;
      end
    end else begin
      // Walk offsets downward so the smallest offset from i_ptr is the last writer.
      for (int k = NREQ - 1; k >= 0; k--) begin
        w_sum = int'(i_ptr) + k;
        if (w_sum >= NREQ) w_sum = w_sum - NREQ;
        w_cand = IDW'(w_sum);
        if (i_req[w_cand]) begin
          o_valid    = 1'b1;
          o_grant_id = w_cand;
        end
      end
    end
    if (o_valid) o_grant[o_grant_id] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART sender among NREQ byte producers with round-robin arbitration,
// packet locking, an optional inter-frame gap and a start-acknowledge timeout.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int IDW           = 2,
  parameter int GAP_CYCLES    = 0,
  parameter int START_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_status,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(START_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic            r_lock, w_lock_nxt;
  logic [CW-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_en, w_tx_en_nxt;
  logic [IDW-1:0]  r_grant_id, w_grant_id_nxt;
  logic            r_busy;
  logic            r_err, w_err_nxt;

  logic [NREQ-1:0] w_arb_grant;
  logic [IDW-1:0]  w_arb_id;
  logic            w_arb_valid;
  logic [7:0]      w_sel_byte;
  logic [IDW-1:0]  w_ptr_after;
  logic [CW-1:0]   w_to_inc;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req      (req),
    .i_ptr      (r_ptr),
    .i_lock     (r_lock),
    .i_lock_id  (r_grant_id),
    .o_grant    (w_arb_grant),
    .o_grant_id (w_arb_id),
    .o_valid    (w_arb_valid)
  );

  assign w_sel_byte  = data[{w_arb_id, 3'b000} +: 8];
  assign w_ptr_after = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_to_inc    = r_to_cnt + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_nxt     = r_lock;
    w_to_cnt_nxt   = r_to_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_ack_nxt      = '0;
    w_tx_en_nxt    = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_grant_id_nxt = r_grant_id;
    w_err_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_status && w_arb_valid) begin
          w_state_nxt    = ST_LAUNCH;
          w_grant_id_nxt = w_arb_id;
          w_tx_data_nxt  = w_sel_byte;
          w_tx_en_nxt    = 1'b1;
          w_ack_nxt      = w_arb_grant;
        end
      end
      ST_LAUNCH: begin
        w_lock_nxt   = ~last[r_grant_id];
        if (last[r_grant_id]) w_ptr_nxt = w_ptr_after;
        w_to_cnt_nxt = '0;
        w_state_nxt  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!tx_status) begin
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_to_cnt_nxt = w_to_inc;
          if (w_to_inc == TO_LIMIT) begin
            w_err_nxt   = 1'b1;
            w_lock_nxt  = 1'b0;
            w_ptr_nxt   = w_ptr_after;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (tx_status) begin
          w_gap_cnt_nxt = '0;
          if (GAP_CYCLES == 0) begin
            w_state_nxt = ST_IDLE;
            if (r_lock && !req[r_grant_id]) begin
              w_lock_nxt = 1'b0;
              w_ptr_nxt  = w_ptr_after;
            end
          end else begin
            w_state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          // Owner dropped its request mid-packet: release the lock.
          if (r_lock && !req[r_grant_id]) begin
            w_lock_nxt = 1'b0;
            w_ptr_nxt  = w_ptr_after;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_to_cnt   <= '0;
      r_gap_cnt  <= '0;
      r_ack      <= '0;
      r_tx_data  <= '0;
      r_tx_en    <= 1'b0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock     <= w_lock_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_en    <= w_tx_en_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_err      <= w_err_nxt;
    end
  end

  assign ack         = r_ack;
  assign tx_data     = r_tx_data;
  assign tx_en       = r_tx_en;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: directed requester queues feed the DUT, a sender model answers tx_en,
// and a negedge monitor pops expected {id, byte} launches and checks timing rules.
module tb_uart_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int GAP   = 2;
  localparam int TMO   = 16;
  localparam int FRAME = 10;

  logic              CLK = 1'b0;
  logic              Reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_status;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err_timeout;

  uart_tx_scheduler #(
    .NREQ          (NREQ),
    .IDW           (IDW),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (TMO)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .req         (req),
    .data        (data),
    .last        (last),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_status   (tx_status),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Sender model
  logic s_status     = 1'b1;
  int   s_left       = 0;
  logic s_stuck      = 1'b0;
  logic foreign_busy = 1'b0;
  logic [7:0] s_byte = 8'h00;
  logic s_reset_seen = 1'b0;
  int   rise_cyc     = 0;
  logic rise_valid   = 1'b0;

  assign tx_status = s_status & ~foreign_busy;

  initial begin
    logic       en_s;
    logic       rst_s;
    logic [7:0] td_s;
    forever begin
      @(posedge CLK);
      en_s  = tx_en;
      rst_s = Reset;
      td_s  = tx_data;
      #1;
      if (s_left > 0) begin
        if (rst_s) s_reset_seen = 1'b1;
        s_left--;
        if (s_left == 0) begin
          s_status   = 1'b1;
          rise_cyc   = cyc;
          rise_valid = 1'b1;
          if (!s_reset_seen) check("frame_data_stable", 32'(tx_data), 32'(s_byte));
        end
      end else if (en_s && !s_stuck) begin
        s_status     = 1'b0;
        s_left       = FRAME;
        s_byte       = td_s;
        s_reset_seen = 1'b0;
      end
    end
  end

  // Requesters
  logic [8:0] rq_mem [NREQ][8];
  int         rq_len [NREQ];
  int         rq_pos [NREQ];
  logic [IDW+7:0] exp_q[$];

  task automatic present(input int i);
    if (rq_pos[i] < rq_len[i]) begin
      data[8*i +: 8] = rq_mem[i][rq_pos[i]][7:0];
      last[i]        = rq_mem[i][rq_pos[i]][8];
      req[i]         = 1'b1;
    end else begin
      req[i]  = 1'b0;
      last[i] = 1'b0;
    end
  endtask

  task automatic present_all();
    for (int i = 0; i < NREQ; i++) present(i);
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input logic l);
    rq_mem[i][rq_len[i]] = {l, b};
    rq_len[i]++;
  endtask

  task automatic expect_launch(input int i, input logic [7:0] b);
    exp_q.push_back({IDW'(i), b});
  endtask

  initial begin
    logic [NREQ-1:0] a;
    forever begin
      @(negedge CLK);
      a = ack;
      if (a != '0) begin
        @(posedge CLK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
          if (a[i]) begin
            rq_pos[i]++;
            present(i);
          end
        end
      end
    end
  end

  // Monitor
  logic prev_en         = 1'b0;
  logic gap_chk         = 1'b0;
  int   launches        = 0;
  int   last_launch_cyc = 0;
  int   err_cnt         = 0;
  int   err_base        = 0;

  initial begin
    logic [IDW+7:0] e;
    forever begin
      @(negedge CLK);
      if (tx_en) begin
        check("tx_en_single_cycle", 32'(prev_en), 32'd0);
        check("launch_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("grant_id", 32'(grant_id), 32'(e[IDW+7:8]));
          check("tx_data", 32'(tx_data), 32'(e[7:0]));
          check("ack_onehot", 32'(ack), 32'(4'b0001 << e[IDW+7:8]));
        end
        if (gap_chk && rise_valid) check("gap_spacing", cyc - rise_cyc, GAP + 2);
        rise_valid      = 1'b0;
        last_launch_cyc = cyc;
        launches++;
      end else if (ack != '0) begin
        check("ack_without_tx_en", 32'(ack), 32'd0);
      end
      if (err_timeout) begin
        err_cnt++;
        check("timeout_latency", cyc - last_launch_cyc, TMO + 1);
        check("idle_on_timeout", 32'(busy), 32'd0);
      end
      prev_en = tx_en;
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    last  = '0;
    data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_len[i] = 0;
      rq_pos[i] = 0;
    end
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1;
    Reset      = 1'b0;
    rise_valid = 1'b0;
    gap_chk    = 1'b0;
    err_base   = err_cnt;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !busy && s_status && req == '0) done = 1'b1;
    end
    check({"drain_", name}, 32'(done), 32'd1);
  endtask

  task automatic end_test(input string name, input int want_err);
    check({name, "_err_count"}, err_cnt - err_base, want_err);
  endtask

  initial begin
    int   base;
    int   rel;
    int   cnt;
    logic seen;

    // Reset and idle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("reset_idle_outputs", 32'({tx_en, ack, tx_data, grant_id, busy, err_timeout}), 32'd0);
    end

    // Single byte, then the pointer must sit at 3
    do_reset();
    add_byte(2, 8'h5A, 1'b1);
    expect_launch(2, 8'h5A);
    present_all();
    wait_drain("single", 100);
    check("grant_id_last_owner", 32'(grant_id), 32'd2);
    add_byte(0, 8'h01, 1'b1);
    add_byte(3, 8'h03, 1'b1);
    expect_launch(3, 8'h03);
    expect_launch(0, 8'h01);
    present_all();
    wait_drain("ptr_after_single", 150);
    end_test("single", 0);

    // Round-robin over all four
    do_reset();
    gap_chk = 1'b1;
    add_byte(0, 8'hA0, 1'b1);
    add_byte(0, 8'hA1, 1'b1);
    add_byte(1, 8'hB0, 1'b1);
    add_byte(2, 8'hC0, 1'b1);
    add_byte(3, 8'hD0, 1'b1);
    expect_launch(0, 8'hA0);
    expect_launch(1, 8'hB0);
    expect_launch(2, 8'hC0);
    expect_launch(3, 8'hD0);
    expect_launch(0, 8'hA1);
    present_all();
    wait_drain("round_robin", 300);
    end_test("round_robin", 0);

    // Packet lock: three-byte packet from req0 is not interleaved with req1
    do_reset();
    gap_chk = 1'b1;
    add_byte(0, 8'h40, 1'b0);
    add_byte(0, 8'h41, 1'b0);
    add_byte(0, 8'h42, 1'b1);
    add_byte(1, 8'h50, 1'b1);
    expect_launch(0, 8'h40);
    expect_launch(0, 8'h41);
    expect_launch(0, 8'h42);
    expect_launch(1, 8'h50);
    present_all();
    wait_drain("lock", 300);
    end_test("lock", 0);

    // Abandoned packet: req0 drops after byte 2, req1 granted at the gap end
    do_reset();
    gap_chk = 1'b1;
    add_byte(0, 8'h60, 1'b0);
    add_byte(0, 8'h61, 1'b0);
    add_byte(1, 8'h70, 1'b1);
    expect_launch(0, 8'h60);
    expect_launch(0, 8'h61);
    expect_launch(1, 8'h70);
    present_all();
    wait_drain("abandon", 300);
    end_test("abandon", 0);

    // Start timeout releases the lock and serves the next requester
    do_reset();
    s_stuck = 1'b1;
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b1);
    add_byte(1, 8'h33, 1'b1);
    expect_launch(0, 8'h11);
    expect_launch(1, 8'h33);
    expect_launch(0, 8'h22);
    present_all();
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge CLK);
      if (err_timeout) seen = 1'b1;
    end
    check("timeout_seen", 32'(seen), 32'd1);
    s_stuck = 1'b0;
    wait_drain("timeout", 200);
    end_test("timeout", 1);

    // Sender busy from a foreign source holds off the launch
    do_reset();
    foreign_busy = 1'b1;
    add_byte(3, 8'hE7, 1'b1);
    expect_launch(3, 8'hE7);
    present_all();
    base = launches;
    repeat (20) @(negedge CLK);
    check("no_launch_while_sender_busy", launches - base, 0);
    check("idle_while_sender_busy", 32'(busy), 32'd0);
    foreign_busy = 1'b0;
    rel = cyc;
    wait_drain("busy_sender", 100);
    check("launch_after_release", last_launch_cyc - rel, 1);
    end_test("busy_sender", 0);

    // Reset in WAIT_DONE
    do_reset();
    add_byte(1, 8'hC3, 1'b1);
    expect_launch(1, 8'hC3);
    present_all();
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 2; k++) begin
      @(negedge CLK);
      if (busy && !tx_status && !tx_en) cnt++;
    end
    check("reached_wait_done", cnt, 2);
    Reset = 1'b1;
    @(negedge CLK);
    check("mid_reset_tx_data", 32'(tx_data), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_grant_id", 32'(grant_id), 32'd0);
    Reset = 1'b0;
    wait_drain("mid_reset", 100);
    end_test("mid_reset", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
